cpu_step_controller: RTL and testbench
======================================

Name: cpu_step_controller

Overview:
- 5 MHz-domain sequencer between the 100→5 MHz step synchroniser and the Cpu6502 clock-enable input.
- Replaces the single-cycle clk_en pulse with these run modes: N cycles, one instruction (to next SYNC), and run-to-breakpoint.
- Returns a completion pulse wide enough for the 5→100 MHz synchroniser, plus stop reason and a cumulative cycle count for the values block.

Parameters:
COMPLETE_PULSE_CYCLES, 2, number of i_clk_5mhz cycles o_step_completed is held high (≥1)
MAX_RUN_CYCLES, 1000000, timeout for instruction/breakpoint modes (executed cycles per step)
CNT_W, 32, width of o_cycles_executed

Ports:
i_clk_5mhz  in  1  CPU-domain clock
i_reset_n  in  1  asynchronous active-low reset
i_step  in  1  single-cycle start pulse (synchronised posedge from 100 MHz domain)
i_mode  in  2  0=cycles, 1=instruction, 2=breakpoint, 3=reserved (treated as 0)
i_cycle_count  in  16  cycles to run in mode 0; 0 treated as 1
i_breakpoint_addr  in  16  stop address for mode 2
i_halt  in  1  abort request, level
i_cpu_sync  in  1  Cpu6502 o_sync (opcode fetch cycle)
i_cpu_address  in  16  Cpu6502 o_address
o_cpu_clk_en  out  1  Cpu6502 i_clk_en
o_step_completed  out  1  completion level, COMPLETE_PULSE_CYCLES wide
o_busy  out  1  high in RUN and DONE
o_stop_reason  out  2  0=count, 1=instruction boundary, 2=breakpoint, 3=halt/timeout
o_cycles_executed  out  CNT_W  cumulative enabled CPU cycles since reset

Behaviour:
- Reset is i_reset_n, asynchronous, active-low; clock is i_clk_5mhz.
- Reset values: state IDLE, o_cpu_clk_en=0, o_step_completed=0, o_busy=0, o_stop_reason=0, o_cycles_executed=0. All internal latches and counters are cleared.
- Reset mid-RUN: o_cpu_clk_en drops asynchronously and the step is abandoned with no completion pulse.
- States:
  - IDLE: i_step=1 latches mode, count (0→1), and breakpoint. Clears the per-step counter r_run. Goes to RUN next edge. i_halt is ignored in IDLE.
  - RUN: o_cpu_clk_en = (state==RUN) && !w_stop. The output is combinational so the CPU halts exactly on the stop cycle.
  - Every edge with o_cpu_clk_en=1 increments r_run and o_cycles_executed. o_cycles_executed wraps modulo 2^CNT_W.
  - w_stop in RUN → DONE at the next edge, and o_stop_reason is registered at that edge.
  - DONE: o_step_completed=1 for COMPLETE_PULSE_CYCLES edges, then IDLE. o_cpu_clk_en=0.
- w_stop priority, highest first:
  1. i_halt → reason 3.
  2. Mode 0: r_run==latched count → reason 0.
  3. Mode 1: r_run≥1 && i_cpu_sync → reason 1.
  4. Mode 2: r_run≥1 && i_cpu_sync && i_cpu_address==breakpoint → reason 2.
  5. Modes 1/2: r_run==MAX_RUN_CYCLES → reason 3.
- The r_run≥1 guard guarantees forward progress when a step starts while the CPU is already on a SYNC cycle or on the breakpoint.
- Mode 0 timing: o_cpu_clk_en is high for exactly N consecutive cycles, starting the cycle after i_step is sampled.
- i_step during RUN or DONE is ignored and not queued. Latched parameters are immune to input changes after the start edge.
- i_halt in the same cycle RUN is entered: zero CPU cycles execute, reason 3.
- r_run width is 20 bits minimum, and must be sufficient for MAX_RUN_CYCLES. It saturates and does not wrap.
- i_cpu_sync and i_cpu_address feed o_cpu_clk_en combinationally. The bench must sample them as stable after each edge.

Test Plan:
- Mode 0, count=3, i_step pulse at edge T → o_cpu_clk_en high at edges T+1..T+3. o_step_completed high edges T+4..T+5. Reason 0. o_cycles_executed=3.
- Mode 0, count=0 → exactly 1 enabled cycle. Then a second step with count=5 → o_cycles_executed=6.
- Mode 1, CPU model asserting sync every 4th cycle, step started on a sync cycle → exactly 4 enabled cycles. Stops with sync=1. Reason 1.
- Mode 2, bp=0x8005, sync addresses 0x8000,0x8002,0x8005 → stops at 0x8005 with clk_en low that cycle. Reason 2. Re-step with CPU at 0x8005 still advances ≥1 cycle.
- i_halt asserted on the 3rd RUN cycle of mode 0 count=100 → clk_en drops that cycle. Reason 3. o_cycles_executed=2. Completion pulse is produced.
- i_reset_n low mid-RUN → o_cpu_clk_en=0 immediately, no o_step_completed. Also: i_step during DONE is ignored; MAX_RUN_CYCLES=16 with no sync → reason 3 after 16 cycles.

Source files
------------

// File: rtl/cpu_step_controller.sv
// Step sequencer for the Cpu6502 clock enable: runs N cycles, one instruction,
// or until a breakpoint, then raises a widened completion pulse.
module cpu_step_controller #(
    parameter int unsigned COMPLETE_PULSE_CYCLES = 2,
    parameter int unsigned MAX_RUN_CYCLES        = 1000000,
    parameter int unsigned CNT_W                 = 32
) (
    input  logic             i_clk_5mhz,
    input  logic             i_reset_n,
    input  logic             i_step,
    input  logic [1:0]       i_mode,
    input  logic [15:0]      i_cycle_count,
    input  logic [15:0]      i_breakpoint_addr,
    input  logic             i_halt,
    input  logic             i_cpu_sync,
    input  logic [15:0]      i_cpu_address,
    output logic             o_cpu_clk_en,
    output logic             o_step_completed,
    output logic             o_busy,
    output logic [1:0]       o_stop_reason,
    output logic [CNT_W-1:0] o_cycles_executed
);

    localparam int unsigned RUN_BITS = $clog2(MAX_RUN_CYCLES + 1);
    localparam int unsigned RUN_W    = (RUN_BITS > 20) ? RUN_BITS : 20;
    localparam int unsigned PULSE_W  = (COMPLETE_PULSE_CYCLES > 1) ?
                                       $clog2(COMPLETE_PULSE_CYCLES) : 1;

    localparam logic [RUN_W-1:0]   RUN_LIMIT  = RUN_W'(MAX_RUN_CYCLES);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(COMPLETE_PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_CYCLES = 2'd0,
        MODE_INSN   = 2'd1,
        MODE_BREAK  = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        RSN_COUNT = 2'd0,
        RSN_INSN  = 2'd1,
        RSN_BREAK = 2'd2,
        RSN_ABORT = 2'd3
    } reason_e;

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [15:0]        count_q, count_d;
    logic [15:0]        bp_q, bp_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [PULSE_W-1:0] pulse_q, pulse_d;
    reason_e            reason_q, reason_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;

    logic               stop;
    reason_e            stop_reason;
    logic               run_nonzero;
    logic               clk_en;

    assign run_nonzero = (run_q != '0);

    // Stop decision, highest priority first; it gates the CPU enable in the same cycle.
    always_comb begin
        stop        = 1'b0;
        stop_reason = RSN_COUNT;
        if (state_q == S_RUN) begin
            if (i_halt) begin
                stop        = 1'b1;
                stop_reason = RSN_ABORT;
            end else begin
                case (mode_q)
                    MODE_INSN: begin
                        if (run_nonzero && i_cpu_sync) begin
                            stop        = 1'b1;
                            stop_reason = RSN_INSN;
                        end else if (run_q == RUN_LIMIT) begin
                            stop        = 1'b1;
                            stop_reason = RSN_ABORT;
                        end
                    end
                    MODE_BREAK: begin
                        if (run_nonzero && i_cpu_sync && (i_cpu_address == bp_q)) begin
                            stop        = 1'b1;
                            stop_reason = RSN_BREAK;
                        end else if (run_q == RUN_LIMIT) begin
                            stop        = 1'b1;
                            stop_reason = RSN_ABORT;
                        end
                    end
                    default: begin
                        if (run_q == RUN_W'(count_q)) begin
                            stop        = 1'b1;
                            stop_reason = RSN_COUNT;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        count_d  = count_q;
        bp_d     = bp_q;
        run_d    = run_q;
        pulse_d  = pulse_q;
        reason_d = reason_q;
        cycles_d = cycles_q;
        clk_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_step) begin
                    case (i_mode)
                        2'd1:    mode_d = MODE_INSN;
                        2'd2:    mode_d = MODE_BREAK;
                        default: mode_d = MODE_CYCLES;
                    endcase
                    count_d = (i_cycle_count == '0) ? 16'd1 : i_cycle_count;
                    bp_d    = i_breakpoint_addr;
                    run_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                clk_en = !stop;
                if (clk_en) begin
                    // Per-step counter saturates; the cumulative count wraps.
                    run_d    = (run_q == '1) ? run_q : run_q + RUN_W'(1);
                    cycles_d = cycles_q + CNT_W'(1);
                end
                if (stop) begin
                    reason_d = stop_reason;
                    pulse_d  = '0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (pulse_q == PULSE_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    pulse_d = pulse_q + PULSE_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_5mhz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_CYCLES;
            count_q  <= '0;
            bp_q     <= '0;
            run_q    <= '0;
            pulse_q  <= '0;
            reason_q <= RSN_COUNT;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            count_q  <= count_d;
            bp_q     <= bp_d;
            run_q    <= run_d;
            pulse_q  <= pulse_d;
            reason_q <= reason_d;
            cycles_q <= cycles_d;
        end
    end

    assign o_cpu_clk_en      = clk_en;
    assign o_step_completed  = (state_q == S_DONE);
    assign o_busy            = (state_q != S_IDLE);
    assign o_stop_reason     = reason_q;
    assign o_cycles_executed = cycles_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Scoreboard bench for cpu_step_controller: expected step results are queued at
// each start and compared when the completion pulse rises.
module tb_cpu_step_controller;

    logic        clk;
    logic        rst_n;
    logic        step;
    logic [1:0]  mode;
    logic [15:0] cnt;
    logic [15:0] bp;
    logic        halt;
    logic        sync;
    logic [15:0] addr;
    logic        clk_en;
    logic        completed;
    logic        busy;
    logic [1:0]  reason;
    logic [31:0] cycles;

    cpu_step_controller #(
        .COMPLETE_PULSE_CYCLES(2),
        .MAX_RUN_CYCLES(16),
        .CNT_W(32)
    ) dut (
        .i_clk_5mhz(clk),
        .i_reset_n(rst_n),
        .i_step(step),
        .i_mode(mode),
        .i_cycle_count(cnt),
        .i_breakpoint_addr(bp),
        .i_halt(halt),
        .i_cpu_sync(sync),
        .i_cpu_address(addr),
        .o_cpu_clk_en(clk_en),
        .o_step_completed(completed),
        .o_busy(busy),
        .o_stop_reason(reason),
        .o_cycles_executed(cycles)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    typedef struct {
        logic [1:0]  rsn;
        logic [31:0] cyc;
        int unsigned en;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned en_cnt   = 0;
    int unsigned comp_len = 0;
    int unsigned tot      = 0;
    int unsigned cpu_ph   = 0;
    bit          nosync   = 1'b0;
    bit          comp_prev = 1'b0;
    logic [15:0] insn_addr [8] = '{16'h8000, 16'h8002, 16'h8005, 16'h8007,
                                   16'h800A, 16'h800C, 16'h800F, 16'h8011};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // CPU model: an opcode fetch every 4th enabled cycle, walking insn_addr.
    task automatic drive_cpu();
        sync = !nosync && (cpu_ph % 4 == 0);
        addr = sync ? insn_addr[(cpu_ph / 4) % 8] : 16'h1234;
    endtask

    task automatic cycle();
        logic en_prev;
        exp_t e;
        @(negedge clk);
        en_prev = clk_en;
        @(posedge clk);
        #1;
        if (en_prev) begin
            en_cnt++;
            cpu_ph++;
        end
        drive_cpu();
        if (completed && !comp_prev) begin
            comp_len = 0;
            if (sb.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("stop_reason", 64'(reason), 64'(e.rsn));
                check("cycles_executed", 64'(cycles), 64'(e.cyc));
                check("enabled_cycles", 64'(en_cnt), 64'(e.en));
            end
        end
        if (completed) comp_len++;
        else if (comp_prev) check("pulse_width", 64'(comp_len), 64'd2);
        comp_prev = completed;
    endtask

    task automatic push_exp(input logic [1:0] r, input int unsigned n);
        exp_t e;
        tot   = tot + n;
        e.rsn = r;
        e.cyc = tot;
        e.en  = n;
        sb.push_back(e);
    endtask

    // Inputs are scrambled after the start edge; the DUT must use its latched copies.
    task automatic start_step(input logic [1:0] m, input logic [15:0] c, input logic [15:0] b);
        en_cnt = 0;
        mode   = m;
        cnt    = c;
        bp     = b;
        step   = 1'b1;
        cycle();
        step   = 1'b0;
        mode   = 2'($urandom_range(3, 0));
        cnt    = 16'($urandom);
        bp     = 16'($urandom);
    endtask

    task automatic run_until_idle();
        int unsigned n;
        n = 0;
        while (busy && n < 200) begin
            cycle();
            n++;
        end
        check("idle_within_bound", 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        rst_n = 1'b0;
        step  = 1'b0;
        halt  = 1'b0;
        mode  = 2'd0;
        cnt   = 16'd0;
        bp    = 16'd0;
        drive_cpu();
        #250;
        check("rst_clk_en", 64'(clk_en), 64'd0);
        check("rst_completed", 64'(completed), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_reason", 64'(reason), 64'd0);
        check("rst_cycles", 64'(cycles), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();

        // Mode 0, count 3: enable begins the cycle right after the start edge.
        push_exp(2'd0, 3);
        start_step(2'd0, 16'd3, 16'd0);
        check("m0_first_en", 64'(clk_en), 64'd1);
        run_until_idle();

        // Count 0 runs one cycle; then count 5.
        push_exp(2'd0, 1);
        start_step(2'd0, 16'd0, 16'd0);
        run_until_idle();
        push_exp(2'd0, 5);
        start_step(2'd0, 16'd5, 16'd0);
        run_until_idle();

        // Reserved mode behaves as cycle mode.
        push_exp(2'd0, 2);
        start_step(2'd3, 16'd2, 16'd0);
        run_until_idle();

        // Instruction mode started on a SYNC cycle.
        cpu_ph = 0;
        drive_cpu();
        push_exp(2'd1, 4);
        start_step(2'd1, 16'd0, 16'd0);
        run_until_idle();
        check("insn_stop_on_sync", 64'(sync), 64'd1);

        // Breakpoint at 0x8005, reached at the third fetch.
        cpu_ph = 0;
        drive_cpu();
        push_exp(2'd2, 8);
        start_step(2'd2, 16'd0, 16'h8005);
        run_until_idle();
        check("bp_stop_addr", 64'(addr), 64'h8005);
        // Re-step while sitting on the breakpoint: must advance, then time out.
        push_exp(2'd3, 16);
        start_step(2'd2, 16'd0, 16'h8005);
        run_until_idle();

        // Halt on the third RUN cycle of a long count.
        push_exp(2'd3, 2);
        start_step(2'd0, 16'd100, 16'd0);
        cycle();
        cycle();
        halt = 1'b1;
        #1;
        check("halt_en_drop", 64'(clk_en), 64'd0);
        cycle();
        halt = 1'b0;
        run_until_idle();

        // Halt already present when RUN is entered.
        halt = 1'b1;
        push_exp(2'd3, 0);
        start_step(2'd0, 16'd10, 16'd0);
        check("halt_entry_en", 64'(clk_en), 64'd0);
        cycle();
        halt = 1'b0;
        run_until_idle();

        // Timeout with no SYNC at all.
        nosync = 1'b1;
        drive_cpu();
        push_exp(2'd3, 16);
        start_step(2'd1, 16'd0, 16'd0);
        run_until_idle();
        nosync = 1'b0;
        drive_cpu();

        // A step pulse during DONE is dropped.
        push_exp(2'd0, 2);
        start_step(2'd0, 16'd2, 16'd0);
        n = 0;
        while (!completed && n < 50) begin
            cycle();
            n++;
        end
        check("done_reached", 64'(completed), 64'd1);
        step = 1'b1;
        mode = 2'd0;
        cnt  = 16'd4;
        cycle();
        step = 1'b0;
        run_until_idle();
        repeat (3) cycle();
        check("done_step_ignored_busy", 64'(busy), 64'd0);
        check("done_step_ignored_cycles", 64'(cycles), 64'(tot));

        // Asynchronous reset in the middle of a run.
        start_step(2'd0, 16'd50, 16'd0);
        repeat (3) cycle();
        #50;
        rst_n = 1'b0;
        #1;
        check("rst_mid_clk_en", 64'(clk_en), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_cycles", 64'(cycles), 64'd0);
        repeat (4) cycle();
        check("rst_mid_no_done", 64'(completed), 64'd0);
        rst_n = 1'b1;
        tot   = 0;
        cycle();

        push_exp(2'd0, 3);
        start_step(2'd0, 16'd3, 16'd0);
        run_until_idle();

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
